// File: rtl/spn_pkg.sv
// spn_pkg: shared types for the SPN command sequencer.
// Opcode/status/state enums, the queued command record and default widths.
package spn_pkg;

   localparam int DW_DEF = 16;
   localparam int KW_DEF = 32;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_ENC   = 2'b01,
      OP_DEC   = 2'b10,
      OP_UNDEF = 2'b11
   } spn_op_e;

   typedef enum logic [1:0] {
      ST_NONE   = 2'b00,
      ST_ENC_OK = 2'b01,
      ST_DEC_OK = 2'b10,
      ST_ERROR  = 2'b11
   } spn_status_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } spn_state_e;

   // Command record at the default widths; the sequencer declares the same
   // layout at its own DW/KW and hands it to the FIFO as a type parameter.
   typedef struct packed {
      spn_op_e             opcode;
      logic [DW_DEF-1:0]   data;
      logic [KW_DEF-1:0]   key;
   } spn_cmd_t;

endpackage

// File: rtl/spn_cmd_fifo.sv
// spn_cmd_fifo: synchronous FIFO of command records.
// DEPTH must be a power of two so the pointers wrap naturally.
// Push while full and pop while empty are ignored.
module spn_cmd_fifo
   import spn_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type cmd_t = spn_cmd_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  cmd_t                     push_data,
   input  logic                     pop,
   output cmd_t                     head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   cmd_t          mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Next pointer and occupancy; simultaneous push and pop keeps the count.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/spn_cmd_sequencer.sv
// spn_cmd_sequencer: queues host commands and issues them one at a time to
// an SPN core, then holds the core's result until the host takes it.
// Optional macro SPN_TIMEOUT_EN: abandons a core wait after TIMEOUT cycles
// and reports status 11 with zero data. Without it, WAIT has no limit.
module spn_cmd_sequencer
   import spn_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int KW      = KW_DEF,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_opcode,
   input  logic [DW-1:0]            cmd_data,
   input  logic [KW-1:0]            cmd_key,
   output logic [1:0]               core_opcode,
   output logic [DW-1:0]            core_data_in,
   output logic [KW-1:0]            core_key,
   input  logic [DW-1:0]            core_data_out,
   input  logic [1:0]               core_valid,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DW-1:0]            rsp_data,
   output logic [1:0]               rsp_status,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   // Same layout as spn_cmd_t, sized to this instance's DW/KW.
   typedef struct packed {
      spn_op_e         opcode;
      logic [DW-1:0]   data;
      logic [KW-1:0]   key;
   } seq_cmd_t;

   spn_state_e    state_q, state_d;
   spn_op_e       core_opcode_q, core_opcode_d;
   logic [DW-1:0] core_data_in_q, core_data_in_d;
   logic [KW-1:0] core_key_q, core_key_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   spn_status_e   rsp_status_q, rsp_status_d;

   seq_cmd_t      push_cmd, fifo_head;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;

`ifdef SPN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   // Nops are handshaken like any command but never stored.
   assign cmd_ready        = !fifo_full;
   assign fifo_push        = cmd_valid && cmd_ready && (cmd_opcode != 2'b00);
   assign push_cmd.opcode  = spn_op_e'(cmd_opcode);
   assign push_cmd.data    = cmd_data;
   assign push_cmd.key     = cmd_key;

   spn_cmd_fifo #(
      .DEPTH (DEPTH),
      .cmd_t (seq_cmd_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_cmd),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign core_opcode  = core_opcode_q;
   assign core_data_in = core_data_in_q;
   assign core_key     = core_key_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_status   = rsp_status_q;

   // Next-state and output logic of the issue/wait/respond sequence.
   always_comb begin
      state_d        = state_q;
      core_opcode_d  = core_opcode_q;
      core_data_in_d = core_data_in_q;
      core_key_d     = core_key_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_data_d     = rsp_data_q;
      rsp_status_d   = rsp_status_q;
      fifo_pop       = 1'b0;
`ifdef SPN_TIMEOUT_EN
      tmo_d          = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            core_opcode_d = OP_NOP;
            if (!fifo_empty) begin
               fifo_pop       = 1'b1;
               core_opcode_d  = fifo_head.opcode;
               core_data_in_d = fifo_head.data;
               core_key_d     = fifo_head.key;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Opcode is a one-cycle strobe; data and key stay on the bus.
            core_opcode_d = OP_NOP;
`ifdef SPN_TIMEOUT_EN
            tmo_d         = '0;
`endif
            if (core_valid != 2'b00) begin
               rsp_valid_d  = 1'b1;
               rsp_data_d   = core_data_out;
               rsp_status_d = spn_status_e'(core_valid);
               state_d      = S_RESP;
            end else begin
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (core_valid != 2'b00) begin
               rsp_valid_d  = 1'b1;
               rsp_data_d   = core_data_out;
               rsp_status_d = spn_status_e'(core_valid);
               state_d      = S_RESP;
            end else begin
`ifdef SPN_TIMEOUT_EN
               if (tmo_q == TW'(TIMEOUT - 1)) begin
                  rsp_valid_d  = 1'b1;
                  rsp_data_d   = '0;
                  rsp_status_d = ST_ERROR;
                  state_d      = S_RESP;
               end else begin
                  tmo_d        = tmo_q + 1'b1;
               end
`else
               // No limit: keep waiting for the core.
               state_d = S_WAIT;
`endif
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, core-side and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         core_opcode_q  <= OP_NOP;
         core_data_in_q <= '0;
         core_key_q     <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_status_q   <= ST_NONE;
      end else begin
         state_q        <= state_d;
         core_opcode_q  <= core_opcode_d;
         core_data_in_q <= core_data_in_d;
         core_key_q     <= core_key_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         rsp_status_q   <= rsp_status_d;
      end
   end

`ifdef SPN_TIMEOUT_EN
   // Wait-cycle counter for the core response limit.
   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

endmodule

// File: tb/tb_spn_cmd_sequencer.sv
// tb_spn_cmd_sequencer: scoreboard bench for spn_cmd_sequencer with a
// behavioural SPN core. Honours SPN_TIMEOUT_EN the same way as the design.
module tb_spn_cmd_sequencer;
   import spn_pkg::*;

   localparam int DW      = 16;
   localparam int KW      = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;
   localparam int CW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_opcode = 2'b00;
   logic [DW-1:0] cmd_data = '0;
   logic [KW-1:0] cmd_key = '0;
   logic [1:0]    core_opcode;
   logic [DW-1:0] core_data_in;
   logic [KW-1:0] core_key;
   logic [DW-1:0] core_data_out = '0;
   logic [1:0]    core_valid = 2'b00;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_status;
   logic [CW-1:0] fifo_count;

   always #5 clk = ~clk;

   spn_cmd_sequencer #(
      .DW (DW), .KW (KW), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_opcode    (cmd_opcode),
      .cmd_data      (cmd_data),
      .cmd_key       (cmd_key),
      .core_opcode   (core_opcode),
      .core_data_in  (core_data_in),
      .core_key      (core_key),
      .core_data_out (core_data_out),
      .core_valid    (core_valid),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_status    (rsp_status),
      .fifo_count    (fifo_count)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [1:0] op; logic [DW-1:0] d; logic [KW-1:0] k; } issue_t;
   typedef struct { logic [DW-1:0] d; logic [1:0] st; } rsp_t;
   issue_t exp_issue[$];
   rsp_t   exp_rsp[$];

   // Core model controls.
   int            core_lat   = 1;
   bit            core_stall = 1'b0;
   bit            core_drop  = 1'b0;
   bit            ovr_en     = 1'b0;
   logic [DW-1:0] ovr_val    = '0;
   bit            exp_tmo    = 1'b0;

   function automatic logic [DW-1:0] core_fn(input logic [1:0] op, input logic [DW-1:0] d,
                                             input logic [KW-1:0] k);
      if (ovr_en) return ovr_val;
      return d ^ k[DW-1:0] ^ ((op == 2'b10) ? 16'h0F0F : 16'h3C3C);
   endfunction

   // Behavioural core: latches an issue strobe, answers core_lat+1 cycles later.
   bit            pend = 1'b0;
   int            pend_cnt = 0;
   logic [1:0]    pend_op = 2'b00;
   logic [DW-1:0] pend_res = '0;
   always @(negedge clk) begin
      core_valid = 2'b00;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend && !core_stall) begin
            if (pend_cnt == 0) begin
               core_valid    = pend_op;
               core_data_out = pend_res;
               pend          = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (core_opcode != 2'b00 && !core_drop) begin
            pend     = 1'b1;
            pend_cnt = core_lat;
            pend_op  = core_opcode;
            pend_res = core_fn(core_opcode, core_data_in, core_key);
         end
      end
   end

   // Monitor: compares issued commands and accepted responses to the scoreboard.
   int     issue_cnt = 0;
   int     max_cnt = 0;
   issue_t mi;
   rsp_t   mr;
   always @(negedge clk) begin
      if (!rst) begin
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (core_opcode != 2'b00) begin
            issue_cnt++;
            if (exp_issue.size() == 0) check("unexpected_issue", 1, 0);
            else begin
               mi = exp_issue.pop_front();
               check("issue_op", core_opcode, mi.op);
               check("issue_data", core_data_in, mi.d);
               check("issue_key", core_key, mi.k);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
            else begin
               mr = exp_rsp.pop_front();
               check("rsp_data", rsp_data, mr.d);
               check("rsp_status", rsp_status, mr.st);
            end
         end
      end
   end

   // Drive one command (entered and left at a negedge); records expectations on acceptance.
   task automatic send(input logic [1:0] op, input logic [DW-1:0] d, input logic [KW-1:0] k);
      int   n = 0;
      rsp_t r;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_data   = d;
      cmd_key    = k;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check("cmd_ready_wait", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (op != 2'b00) begin
         exp_issue.push_back('{op, d, k});
         if (exp_tmo) begin
            r.d  = '0;
            r.st = 2'b11;
         end else begin
            r.d  = core_fn(op, d, k);
            r.st = op;
         end
         exp_rsp.push_back(r);
      end
      @(negedge clk);
   endtask

   task automatic wait_drain(input int lim);
      int n = 0;
      while (exp_rsp.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", exp_rsp.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fifo_count"}, fifo_count, 0);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_core_opcode"}, core_opcode, 0);
      check({tag, "_core_data_in"}, core_data_in, 0);
      check({tag, "_core_key"}, core_key, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_rsp_status"}, rsp_status, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   ic;
      bit   seen;
      rsp_t r0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      #1 rst = 1'b0;
      @(negedge clk);

      // Single encrypt: one-cycle issue strobe, minimum latency, fixed result.
      ovr_en  = 1'b1;
      ovr_val = 16'hA5A5;
      core_lat = 1;
      ic = issue_cnt;
      send(2'b01, 16'h1234, 32'hDEADBEEF);
      cmd_valid = 1'b0;
      check("t1_not_yet_issued", core_opcode, 2'b00);
      @(negedge clk);
      check("t1_issue_cycle", core_opcode, 2'b01);
      check("t1_fifo_popped", fifo_count, 0);
      @(negedge clk);
      check("t1_strobe_end", core_opcode, 2'b00);
      check("t1_data_held", core_data_in, 16'h1234);
      check("t1_key_held", core_key, 32'hDEADBEEF);
      wait_drain(50);
      check("t1_issue_pulses", issue_cnt - ic, 1);
      ovr_en = 1'b0;

      // Five back-to-back commands with the core stalled, then one more under backpressure.
      core_stall = 1'b1;
      for (int i = 0; i < 5; i++)
         send((i % 2 == 0) ? 2'b01 : 2'b10, DW'(16'h1000 + i), KW'(32'hC0DE0000 + i));
      cmd_valid = 1'b0;
      check("t2_fifo_full_count", fifo_count, DEPTH);
      check("t2_cmd_ready_low", cmd_ready, 0);
      core_stall = 1'b0;
      send(2'b11, 16'h7777, 32'h01234567);
      cmd_valid = 1'b0;
      wait_drain(500);

      // Nop is discarded; only the decrypt reaches the core.
      max_cnt = 0;
      ic = issue_cnt;
      send(2'b00, 16'hBEEF, 32'hFFFFFFFF);
      send(2'b10, 16'h00FF, 32'h12345678);
      cmd_valid = 1'b0;
      wait_drain(50);
      check("t3_fifo_peak", max_cnt, 1);
      check("t3_issue_count", issue_cnt - ic, 1);

      // Response held while the host stalls; next command waits for the handshake.
      rsp_ready = 1'b0;
      send(2'b01, 16'h4321, 32'h0BADF00D);
      send(2'b10, 16'h5555, 32'hFFFF0000);
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_rsp_arrived", rsp_valid, 1);
      r0 = exp_rsp[0];
      ic = issue_cnt;
      repeat (10) begin
         @(negedge clk);
         check("t4_hold_valid", rsp_valid, 1);
         check("t4_hold_data", rsp_data, r0.d);
         check("t4_hold_status", rsp_status, r0.st);
      end
      check("t4_no_issue_in_resp", issue_cnt - ic, 0);
      rsp_ready = 1'b1;
      wait_drain(100);

`ifdef SPN_TIMEOUT_EN
      // Core never answers: response after TIMEOUT wait cycles with status 11.
      core_drop = 1'b1;
      exp_tmo   = 1'b1;
      send(2'b01, 16'h9999, 32'hAAAA5555);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("t5_issue", core_opcode, 2'b01);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t5_timeout_cycles", n, TIMEOUT + 1);
      wait_drain(10);
      core_drop = 1'b0;
      exp_tmo   = 1'b0;
`else
      // Core never answers: no response at all.
      core_drop = 1'b1;
      send(2'b01, 16'h9999, 32'hAAAA5555);
      cmd_valid = 1'b0;
      repeat (100) @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      exp_issue.delete();
      exp_rsp.delete();
      #1 rst = 1'b0;
      core_drop = 1'b0;
      @(negedge clk);
`endif

      // Reset during WAIT with two commands queued.
      core_stall = 1'b1;
      send(2'b01, 16'h0101, 32'h11111111);
      send(2'b10, 16'h0202, 32'h22222222);
      send(2'b01, 16'h0303, 32'h33333333);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_queued", fifo_count, 2);
      rst = 1'b1;
      @(negedge clk);
      exp_issue.delete();
      exp_rsp.delete();
      check_reset_outputs("t6");
      #1 rst = 1'b0;
      core_stall = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("t6_no_rsp_after_rst", seen, 0);

      // Normal operation resumes after reset.
      send(2'b10, 16'hCAFE, 32'h87654321);
      cmd_valid = 1'b0;
      wait_drain(50);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spn_cmd_sequencer.md
SPN_CMD_SEQUENCER -- requirements
Module: spn_cmd_sequencer

Interface
REQ-001 SHALL have parameter DW, 16, data width in bits.
REQ-002 SHALL have parameter KW, 32, key width in bits.
REQ-003 SHALL have parameter DEPTH, 4, command FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, 15, maximum wait cycles for a core response.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port cmd_valid  in  1  host command valid.
REQ-008 SHALL have port cmd_ready  out  1  FIFO can accept a command.
REQ-009 SHALL have port cmd_opcode  in  2  00 nop, 01 enc, 10 dec, 11 undefined.
REQ-010 SHALL have port cmd_data  in  DW  plaintext or ciphertext.
REQ-011 SHALL have port cmd_key  in  KW  symmetric secret key.
REQ-012 SHALL have port core_opcode  out  2  opcode to SPN core, registered.
REQ-013 SHALL have port core_data_in  out  DW  data to SPN core, registered.
REQ-014 SHALL have port core_key  out  KW  key to SPN core, registered.
REQ-015 SHALL have port core_data_out  in  DW  SPN core result.
REQ-016 SHALL have port core_valid  in  2  core status: 00 none, 01 enc ok, 10 dec ok, 11 error.
REQ-017 SHALL have port rsp_valid  out  1  response held valid.
REQ-018 SHALL have port rsp_ready  in  1  host accepts response.
REQ-019 SHALL have port rsp_data  out  DW  captured result.
REQ-020 SHALL have port rsp_status  out  2  captured core_valid code, or 11 on timeout.
REQ-021 SHALL have port fifo_count  out  $clog2(DEPTH)+1  queued command count.

Function
REQ-022 SHALL assert cmd_ready whenever fifo_count < DEPTH (registered count, no same-cycle pop bypass).
REQ-023 SHALL enqueue {opcode,data,key} on cmd_valid && cmd_ready when cmd_opcode != 00; nop commands SHALL be accepted and discarded.
REQ-024 SHALL forward opcode 11 to the core unchanged; the core reports the error.
REQ-025 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-026 IDLE: when FIFO non-empty, SHALL pop head, load core_* registers, move to ISSUE on the same edge; else core_opcode SHALL stay 00.
REQ-027 ISSUE: core_opcode SHALL hold the command for exactly one cycle; next edge SHALL set core_opcode=00 (core_data_in/core_key held) and enter WAIT.
REQ-028 ISSUE and WAIT: SHALL sample core_valid; on non-00 SHALL capture core_data_out into rsp_data and core_valid into rsp_status, and enter RESP.
REQ-029 RESP: rsp_valid SHALL be 1 with stable data/status until rsp_valid && rsp_ready; then SHALL clear rsp_valid and return to IDLE.
REQ-030 Minimum latency: push at edge k into empty FIFO -> core_opcode valid during cycle k+1..k+2; one command in flight at a time.
REQ-031 FIFO push and pop in the same cycle SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-032 Pushes SHALL continue during ISSUE/WAIT/RESP while not full; FIFO order SHALL be preserved.

Reset
REQ-033 On rst at a rising edge: FSM=IDLE, FIFO empty, fifo_count=0, cmd_ready=1 from next cycle, core_opcode=00, core_data_in=0, core_key=0, rsp_valid=0, rsp_data=0, rsp_status=00, timeout counter=0.
REQ-034 Reset mid-operation SHALL discard queued and in-flight commands; no response SHALL be produced for them.

Configuration
REQ-035 With SPN_TIMEOUT_EN defined, a counter SHALL run in WAIT; if TIMEOUT cycles pass without non-00 core_valid, SHALL set rsp_data=0, rsp_status=11, enter RESP.
REQ-036 Without SPN_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist until core_valid != 00.

Structure
REQ-037 spn_pkg SHALL hold opcode enum, status enum, FSM state enum, command struct {opcode,data,key}, default DW/KW.
REQ-038 The FIFO SHALL be sub-module spn_cmd_fifo (parameterized DEPTH, command-struct payload).

Verification
REQ-039 Push enc 0x1234 key 0xDEADBEEF, core returns 0xA5A5/01 two cycles later -> rsp_data=0xA5A5, rsp_status=01, core_opcode 01 for exactly one cycle.
REQ-040 Push 5 commands back-to-back with DEPTH=4, core stalled -> cmd_ready low after 4th queued; all 5 responses returned in order.
REQ-041 Push nop then dec 0x00FF -> only dec reaches core; fifo_count peaks at 1.
REQ-042 SPN_TIMEOUT_EN on, core_valid held 00 -> after 15 WAIT cycles rsp_status=11, rsp_data=0; off -> no response after 100 cycles.
REQ-043 rsp_ready held low 10 cycles in RESP -> rsp_data/status stable, next command not issued until handshake.
REQ-044 rst asserted during WAIT with 2 queued -> all outputs at reset values next cycle, no response issued.
